ram_loader: RTL

Streams a length-prefixed byte image into the `ram` block before the CPU runs. Sits directly upstream of `ram` and drives its `write_enable`, `address` and `data_in` ports from a valid/ready byte source such as a UART receiver. The core's RAM port mux selects the loader while `busy` is high. `done` signals the CPU may be released; `error` signals the image was rejected.

---
 rtl/ram_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
// ram_loader: streams a length-prefixed byte image into a level-sensitive RAM
// before the CPU is released.
//
// Stream format: len[7:0], len[15:8], then len payload bytes that are written to
// addresses 0..len-1. Each payload byte becomes one single-cycle write pulse.
// Address and data change only on the edge that raises the write pulse.
//
// Ports:
//   clk              in   clock, rising edge
//   rst_n            in   synchronous active-low reset
//   start            in   begin a load (honoured only in IDLE, DONE or ERROR)
//   in_valid         in   source byte valid
//   in_data          in   source byte
//   in_ready         out  loader accepts in_data this cycle
//   ram_write_enable out  RAM write strobe (single-cycle pulse)
//   ram_address      out  RAM address
//   ram_data_in      out  RAM write data
//   busy             out  load in progress
//   done             out  last load completed (sticky until next start)
//   error            out  last load rejected as oversize (sticky until next start)
module ram_loader #(
    parameter int addr_bits = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 ram_write_enable,
    output logic [addr_bits-1:0] ram_address,
    output logic [7:0]           ram_data_in,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_e;

    // Largest image that fits: 2^addr_bits bytes.
    localparam logic [16:0] LEN_LIMIT = 17'(1) << addr_bits;

    state_e               state_q;
    logic [15:0]          len_q;
    logic [16:0]          count_q;
    logic                 in_ready_q;
    logic                 we_q;
    logic [addr_bits-1:0] addr_q;
    logic [7:0]           data_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;

    logic                 xfer;
    logic [15:0]          len_d;

    // in_ready_q is only ever set in LEN_LO, LEN_HI and DATA, so it alone
    // qualifies a transfer.
    assign xfer  = in_valid && in_ready_q;
    // Full length as it will be once the high byte lands.
    assign len_d = {in_data, len_q[7:0]};

    // NOTE: all state lives in one clocked block using non-blocking
    // assignments, so every register samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q    <= S_LEN_LO;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_q[7:0] <= in_data;
                        state_q    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len_q[15:8] <= in_data;
                        count_q     <= '0;
                        if (len_d == 16'd0) begin
                            state_q    <= S_DONE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else if ({1'b0, len_d} > LEN_LIMIT) begin
                            state_q    <= S_ERROR;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    // Address and data move together with the rising strobe,
                    // never while it is high or as it falls.
                    if (xfer) begin
                        addr_q     <= count_q[addr_bits-1:0];
                        data_q     <= in_data;
                        we_q       <= 1'b1;
                        count_q    <= count_q + 17'd1;
                        in_ready_q <= 1'b0;
                        state_q    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    we_q <= 1'b0;
                    if (count_q == {1'b0, len_q}) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= S_DATA;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    we_q       <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready         = in_ready_q;
    assign ram_write_enable = we_q;
    assign ram_address      = addr_q;
    assign ram_data_in      = data_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;

endmodule
